// File: rtl/br_rs_queue_if.sv
// Dispatch, CDB snoop and issue signals of the branch reservation station.
// The slave modport is the station; the master modport is its surroundings.
interface br_rs_queue_if #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4,
    parameter int OP_W  = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              dispatch_valid;
    logic              dispatch_ready;
    logic [OP_W-1:0]   dispatch_op;
    logic [31:0]       dispatch_pc;
    logic              dispatch_bp_prediction;
    logic [ROB_W-1:0]  dispatch_rob_dest;
    logic              dispatch_q1_valid;
    logic [ROB_W-1:0]  dispatch_q1_tag;
    logic [31:0]       dispatch_q1_data;
    logic              dispatch_q2_valid;
    logic [ROB_W-1:0]  dispatch_q2_tag;
    logic [31:0]       dispatch_q2_data;

    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob_entry;
    logic [31:0]       cdb_data;

    logic              br_ready;
    logic              rs_br_start;
    logic [OP_W-1:0]   issue_op;
    logic [31:0]       issue_pc;
    logic              issue_bp_prediction;
    logic [ROB_W-1:0]  issue_rob_dest;
    logic [31:0]       issue_q1_data;
    logic [31:0]       issue_q2_data;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_pc, dispatch_bp_prediction,
               dispatch_rob_dest, dispatch_q1_valid, dispatch_q1_tag, dispatch_q1_data,
               dispatch_q2_valid, dispatch_q2_tag, dispatch_q2_data,
               cdb_valid, cdb_rob_entry, cdb_data, br_ready,
        output dispatch_ready, rs_br_start, issue_op, issue_pc, issue_bp_prediction,
               issue_rob_dest, issue_q1_data, issue_q2_data, count
    );

    modport master (
        output dispatch_valid, dispatch_op, dispatch_pc, dispatch_bp_prediction,
               dispatch_rob_dest, dispatch_q1_valid, dispatch_q1_tag, dispatch_q1_data,
               dispatch_q2_valid, dispatch_q2_tag, dispatch_q2_data,
               cdb_valid, cdb_rob_entry, cdb_data, br_ready,
        input  dispatch_ready, rs_br_start, issue_op, issue_pc, issue_bp_prediction,
               issue_rob_dest, issue_q1_data, issue_q2_data, count
    );
endinterface

// File: rtl/br_rs_queue.sv
// Branch/jalr reservation station: collapsing queue in dispatch order (index 0 oldest),
// CDB operand capture, oldest-ready issue to the branch unit.
module br_rs_queue #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4,
    parameter int OP_W  = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    br_rs_queue_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [31:0]       pc;
        logic              bp;
        logic [ROB_W-1:0]  rob;
        logic              q1_valid;
        logic [ROB_W-1:0]  q1_tag;
        logic [31:0]       q1_data;
        logic              q2_valid;
        logic [ROB_W-1:0]  q2_tag;
        logic [31:0]       q2_data;
    } entry_t;

    entry_t            ent     [DEPTH];
    entry_t            ent_nxt [DEPTH];
    entry_t            disp_ent;
    logic [CNT_W-1:0]  cnt, cnt_nxt, wr_pos;
    logic [IDX_W-1:0]  sel;
    logic              any_ready, start, disp_rdy, disp_acc;

    // Descending scan so the lowest ready index wins.
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent[i].busy && ent[i].q1_valid && ent[i].q2_valid) begin
                any_ready = 1'b1;
                sel       = IDX_W'(i);
            end
        end
    end

    assign disp_rdy = (cnt < CNT_W'(DEPTH));
    assign start    = bus.br_ready & any_ready & ~flush;
    assign disp_acc = bus.dispatch_valid & disp_rdy & ~flush;
    assign wr_pos   = start ? cnt - 1'b1 : cnt;

    assign bus.dispatch_ready      = disp_rdy;
    assign bus.rs_br_start         = start;
    assign bus.issue_op            = ent[sel].op;
    assign bus.issue_pc            = ent[sel].pc;
    assign bus.issue_bp_prediction = ent[sel].bp;
    assign bus.issue_rob_dest      = ent[sel].rob;
    assign bus.issue_q1_data       = ent[sel].q1_data;
    assign bus.issue_q2_data       = ent[sel].q2_data;
    assign bus.count               = cnt;

    always_comb begin
        disp_ent          = '0;
        disp_ent.busy     = 1'b1;
        disp_ent.op       = bus.dispatch_op;
        disp_ent.pc       = bus.dispatch_pc;
        disp_ent.bp       = bus.dispatch_bp_prediction;
        disp_ent.rob      = bus.dispatch_rob_dest;
        disp_ent.q1_valid = bus.dispatch_q1_valid;
        disp_ent.q1_tag   = bus.dispatch_q1_tag;
        disp_ent.q1_data  = bus.dispatch_q1_data;
        disp_ent.q2_valid = bus.dispatch_q2_valid;
        disp_ent.q2_tag   = bus.dispatch_q2_tag;
        disp_ent.q2_data  = bus.dispatch_q2_data;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (flush)
            cnt_nxt = '0;
        else if (disp_acc && !start)
            cnt_nxt = cnt + 1'b1;
        else if (!disp_acc && start)
            cnt_nxt = cnt - 1'b1;
    end

    // Collapse above the issued slot, drop in the dispatch, then snoop the CDB
    // on the final positions (which also covers the dispatch-cycle bypass).
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent_nxt[i] = ent[i];
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (start && IDX_W'(i) >= sel)
                ent_nxt[i] = ent[i + 1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_acc && CNT_W'(i) == wr_pos)
                ent_nxt[i] = disp_ent;
            ent_nxt[i].busy = (CNT_W'(i) < cnt_nxt);
            if (ent_nxt[i].busy && bus.cdb_valid) begin
                if (!ent_nxt[i].q1_valid && ent_nxt[i].q1_tag == bus.cdb_rob_entry) begin
                    ent_nxt[i].q1_valid = 1'b1;
                    ent_nxt[i].q1_data  = bus.cdb_data;
                end
                if (!ent_nxt[i].q2_valid && ent_nxt[i].q2_tag == bus.cdb_rob_entry) begin
                    ent_nxt[i].q2_valid = 1'b1;
                    ent_nxt[i].q2_data  = bus.cdb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= '0;
        end else begin
            cnt <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= ent_nxt[i];
        end
    end
endmodule

// File: tb/tb_br_rs_queue.sv
// Bench for br_rs_queue: expected issues are queued as stimulus is driven and
// popped by a monitor whenever the station strobes rs_br_start.
module tb_br_rs_queue;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    br_rs_queue_if #(.DEPTH(4), .ROB_W(4), .OP_W(3)) bus();

    br_rs_queue #(.DEPTH(4), .ROB_W(4), .OP_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] pc;
        logic        bp;
        logic [3:0]  rob;
        logic [31:0] q1;
        logic [31:0] q2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [2:0] op, input logic [31:0] pc, input logic bp,
                        input logic [3:0] rob,
                        input logic v1, input logic [3:0] t1, input logic [31:0] d1,
                        input logic v2, input logic [3:0] t2, input logic [31:0] d2);
        bus.dispatch_valid         = 1'b1;
        bus.dispatch_op            = op;
        bus.dispatch_pc            = pc;
        bus.dispatch_bp_prediction = bp;
        bus.dispatch_rob_dest      = rob;
        bus.dispatch_q1_valid      = v1;
        bus.dispatch_q1_tag        = t1;
        bus.dispatch_q1_data       = d1;
        bus.dispatch_q2_valid      = v2;
        bus.dispatch_q2_tag        = t2;
        bus.dispatch_q2_data       = d2;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] d);
        bus.cdb_valid     = 1'b1;
        bus.cdb_rob_entry = tag;
        bus.cdb_data      = d;
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid      = 1'b0;
    endtask

    task automatic push(input logic [2:0] op, input logic [31:0] pc, input logic bp,
                        input logic [3:0] rob, input logic [31:0] q1, input logic [31:0] q2);
        exp_t e;
        e = '{op: op, pc: pc, bp: bp, rob: rob, q1: q1, q2: q2};
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.rs_br_start === 1'b1) begin
            exp_t e;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL issue_unexpected: got rob %0d pc %h, want no issue",
                         bus.issue_rob_dest, bus.issue_pc);
            end else begin
                e = sb.pop_front();
                if ({bus.issue_op, bus.issue_pc, bus.issue_bp_prediction, bus.issue_rob_dest,
                     bus.issue_q1_data, bus.issue_q2_data} !==
                    {e.op, e.pc, e.bp, e.rob, e.q1, e.q2}) begin
                    n_err++;
                    $display("FAIL issue_fields: got op %0d pc %h bp %0d rob %0d q1 %h q2 %h, want op %0d pc %h bp %0d rob %0d q1 %h q2 %h",
                             bus.issue_op, bus.issue_pc, bus.issue_bp_prediction, bus.issue_rob_dest,
                             bus.issue_q1_data, bus.issue_q2_data,
                             e.op, e.pc, e.bp, e.rob, e.q1, e.q2);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        idle();
        disp(3'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        bus.dispatch_valid = 1'b0;
        bus.cdb_rob_entry = 4'd0;
        bus.cdb_data = 32'h0;
        bus.br_ready = 1'b1;
        #2;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.dispatch_ready !== 1'b1) begin n_err++; $display("FAIL reset_dispatch_ready: got %b want 1", bus.dispatch_ready); end
        n_cmp++; if (bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", bus.rs_br_start); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        bus.br_ready = 1'b1;
        disp(3'd0, 32'h100, 1'b1, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
        push(3'd0, 32'h100, 1'b1, 4'd3, 32'd5, 32'd5);
        #1;
        n_cmp++; if (bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL basic_empty_start: got %b want 0", bus.rs_br_start); end
        cyc();
        idle();
        #1;
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL basic_count1: got %0d want 1", bus.count); end
        n_cmp++; if (bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL basic_start: got %b want 1", bus.rs_br_start); end
        n_cmp++; if (bus.issue_q1_data !== 32'd5) begin n_err++; $display("FAIL basic_q1: got %h want 5", bus.issue_q1_data); end
        n_cmp++; if (bus.issue_rob_dest !== 4'd3) begin n_err++; $display("FAIL basic_rob: got %0d want 3", bus.issue_rob_dest); end
        cyc();
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL basic_count0: got %0d want 0", bus.count); end
    endtask

    task automatic test_cdb_wakeup();
        bus.br_ready = 1'b1;
        disp(3'd1, 32'h200, 1'b0, 4'd4, 1'b0, 4'd2, 32'h0, 1'b1, 4'd0, 32'd7);
        cyc();
        idle();
        cdb(4'd3, 32'hdead);
        #1;
        n_cmp++; if (bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL cdb_wait_start: got %b want 0", bus.rs_br_start); end
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL cdb_wait_count: got %0d want 1", bus.count); end
        cyc();
        cdb(4'd2, 32'h10);
        push(3'd1, 32'h200, 1'b0, 4'd4, 32'h10, 32'd7);
        #1;
        n_cmp++; if (bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL cdb_same_cycle_start: got %b want 0", bus.rs_br_start); end
        cyc();
        idle();
        #1;
        n_cmp++; if (bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL cdb_wake_start: got %b want 1", bus.rs_br_start); end
        n_cmp++; if (bus.issue_q1_data !== 32'h10) begin n_err++; $display("FAIL cdb_wake_q1: got %h want 10", bus.issue_q1_data); end
        cyc();
        disp(3'd1, 32'h204, 1'b1, 4'd5, 1'b0, 4'd5, 32'h0, 1'b1, 4'd0, 32'd9);
        cdb(4'd5, 32'h22);
        push(3'd1, 32'h204, 1'b1, 4'd5, 32'h22, 32'd9);
        cyc();
        idle();
        #1;
        n_cmp++; if (bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL bypass_start: got %b want 1", bus.rs_br_start); end
        n_cmp++; if (bus.issue_q1_data !== 32'h22) begin n_err++; $display("FAIL bypass_q1: got %h want 22", bus.issue_q1_data); end
        cyc();
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL bypass_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_fill();
        bus.br_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(3'd2, 32'h300 + 32'(4 * k), k[0], 4'(8 + k), 1'b1, 4'd0, 32'h100 + 32'(k),
                 1'b1, 4'd0, 32'(k));
            push(3'd2, 32'h300 + 32'(4 * k), k[0], 4'(8 + k), 32'h100 + 32'(k), 32'(k));
            cyc();
        end
        idle();
        #1;
        n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", bus.count); end
        n_cmp++; if (bus.dispatch_ready !== 1'b0) begin n_err++; $display("FAIL full_dispatch_ready: got %b want 0", bus.dispatch_ready); end
        bus.br_ready = 1'b1;
        disp(3'd3, 32'h400, 1'b0, 4'd12, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
        #1;
        n_cmp++; if (bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL full_issue_start: got %b want 1", bus.rs_br_start); end
        n_cmp++; if (bus.dispatch_ready !== 1'b0) begin n_err++; $display("FAIL full_issue_ready: got %b want 0", bus.dispatch_ready); end
        cyc();
        idle();
        bus.br_ready = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL full_after_count: got %0d want 3", bus.count); end
        n_cmp++; if (bus.dispatch_ready !== 1'b1) begin n_err++; $display("FAIL full_after_ready: got %b want 1", bus.dispatch_ready); end
        bus.br_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL full_drain_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_oldest_ready();
        bus.br_ready = 1'b0;
        disp(3'd4, 32'h500, 1'b0, 4'd5, 1'b0, 4'd1, 32'h0, 1'b1, 4'd0, 32'h33);
        cyc();
        disp(3'd5, 32'h504, 1'b1, 4'd6, 1'b1, 4'd0, 32'h61, 1'b1, 4'd0, 32'h62);
        push(3'd5, 32'h504, 1'b1, 4'd6, 32'h61, 32'h62);
        cyc();
        disp(3'd6, 32'h508, 1'b0, 4'd7, 1'b1, 4'd0, 32'h71, 1'b1, 4'd0, 32'h72);
        push(3'd6, 32'h508, 1'b0, 4'd7, 32'h71, 32'h72);
        cyc();
        idle();
        bus.br_ready = 1'b1;
        #1;
        n_cmp++; if (bus.issue_rob_dest !== 4'd6 || bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL oldest_first: got rob %0d start %b want rob 6 start 1", bus.issue_rob_dest, bus.rs_br_start); end
        cyc();
        #1;
        n_cmp++; if (bus.issue_rob_dest !== 4'd7 || bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL oldest_second: got rob %0d start %b want rob 7 start 1", bus.issue_rob_dest, bus.rs_br_start); end
        cyc();
        #1;
        n_cmp++; if (bus.count !== 3'd1 || bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL oldest_waiting: got count %0d start %b want count 1 start 0", bus.count, bus.rs_br_start); end
        cdb(4'd1, 32'h55);
        push(3'd4, 32'h500, 1'b0, 4'd5, 32'h55, 32'h33);
        cyc();
        idle();
        #1;
        n_cmp++; if (bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL oldest_wake_start: got %b want 1", bus.rs_br_start); end
        cyc();
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL oldest_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_back_to_back();
        bus.br_ready = 1'b0;
        disp(3'd0, 32'h600, 1'b0, 4'd1, 1'b1, 4'd0, 32'ha1, 1'b1, 4'd0, 32'ha2);
        push(3'd0, 32'h600, 1'b0, 4'd1, 32'ha1, 32'ha2);
        cyc();
        disp(3'd1, 32'h604, 1'b1, 4'd2, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'hb2);
        cyc();
        bus.br_ready = 1'b1;
        disp(3'd2, 32'h608, 1'b0, 4'd3, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'hc2);
        #1;
        n_cmp++; if (bus.count !== 3'd2 || bus.rs_br_start !== 1'b1 || bus.dispatch_ready !== 1'b1) begin n_err++; $display("FAIL simul_pre: got count %0d start %b ready %b want 2 1 1", bus.count, bus.rs_br_start, bus.dispatch_ready); end
        cyc();
        idle();
        #1;
        n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL simul_count: got %0d want 2", bus.count); end
        n_cmp++; if (bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL simul_idle_start: got %b want 0", bus.rs_br_start); end
        cdb(4'd9, 32'h99);
        push(3'd1, 32'h604, 1'b1, 4'd2, 32'h99, 32'hb2);
        push(3'd2, 32'h608, 1'b0, 4'd3, 32'h99, 32'hc2);
        cyc();
        idle();
        #1;
        n_cmp++; if (bus.issue_rob_dest !== 4'd2 || bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL simul_index0: got rob %0d start %b want rob 2 start 1", bus.issue_rob_dest, bus.rs_br_start); end
        cyc();
        #1;
        n_cmp++; if (bus.issue_rob_dest !== 4'd3 || bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL simul_index1: got rob %0d start %b want rob 3 start 1", bus.issue_rob_dest, bus.rs_br_start); end
        cyc();
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL simul_drain: got %0d want 0", bus.count); end
    endtask

    task automatic test_flush();
        bus.br_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            disp(3'd0, 32'h700 + 32'(k), 1'b0, 4'(k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'(k));
            cyc();
        end
        flush = 1'b1;
        bus.br_ready = 1'b1;
        disp(3'd0, 32'h780, 1'b0, 4'd4, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
        #1;
        n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d want 3", bus.count); end
        n_cmp++; if (bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL flush_start: got %b want 0", bus.rs_br_start); end
        cyc();
        flush = 1'b0;
        idle();
        #1;
        n_cmp++; if (bus.count !== 3'd0 || bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL flush_after: got count %0d start %b want 0 0", bus.count, bus.rs_br_start); end
        cyc();
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL flush_settled: got %0d want 0", bus.count); end
    endtask

    task automatic test_async_reset();
        bus.br_ready = 1'b0;
        disp(3'd0, 32'h800, 1'b0, 4'd5, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
        cyc();
        disp(3'd0, 32'h804, 1'b0, 4'd6, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 32'd6);
        cyc();
        idle();
        #1;
        n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL areset_pre_count: got %0d want 2", bus.count); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 3'd0 || bus.dispatch_ready !== 1'b1) begin n_err++; $display("FAIL areset_clear: got count %0d ready %b want 0 1", bus.count, bus.dispatch_ready); end
        bus.br_ready = 1'b1;
        #1;
        n_cmp++; if (bus.rs_br_start !== 1'b0) begin n_err++; $display("FAIL areset_start: got %b want 0", bus.rs_br_start); end
        #2;
        rst = 1'b1;
        cyc();
        disp(3'd7, 32'h900, 1'b1, 4'd7, 1'b1, 4'd0, 32'h77, 1'b1, 4'd0, 32'h78);
        push(3'd7, 32'h900, 1'b1, 4'd7, 32'h77, 32'h78);
        cyc();
        idle();
        #1;
        n_cmp++; if (bus.count !== 3'd1 || bus.rs_br_start !== 1'b1) begin n_err++; $display("FAIL areset_redispatch: got count %0d start %b want 1 1", bus.count, bus.rs_br_start); end
        cyc();
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL areset_drain: got %0d want 0", bus.count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cdb_wakeup();
        test_fill();
        test_oldest_ready();
        test_back_to_back();
        test_flush();
        test_async_reset();
        cyc();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d pending issues want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/br_rs_queue.md
# br_rs_queue

Reservation station that sits directly upstream of the branch/jalr calculation unit. It holds up to `DEPTH` dispatched branch/jalr micro-ops and captures missing source operands by snooping the CDB. It issues the oldest fully-ready entry to the branch unit using the `rs_br_start` / `br_ready` handshake. Entries are kept in a collapsing queue in dispatch order, with index 0 always the oldest.

## Interface

Parameters:
- `DEPTH`, 4: number of entries; must be ≥ 2.
- `ROB_W`, 4: ROB tag width.
- `OP_W`, 3: operation encoding width, using the same encodings the branch unit decodes (beq..bgeu, jalr).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: mispredict flush; clears the station synchronously.
- `dispatch_valid` in 1: dispatch request.
- `dispatch_ready` out 1: the station can accept a dispatch this cycle.
- `dispatch_op` in OP_W: operation.
- `dispatch_pc` in 32: instruction PC.
- `dispatch_bp_prediction` in 1: predicted taken.
- `dispatch_rob_dest` in ROB_W: ROB entry of the instruction.
- `dispatch_q1_valid` in 1: operand 1 data is present.
- `dispatch_q1_tag` in ROB_W: producer tag for operand 1 when it is not present.
- `dispatch_q1_data` in 32: operand 1 value.
- `dispatch_q2_valid`, `dispatch_q2_tag`, `dispatch_q2_data`: same as operand 1, for operand 2. Dispatch drives `q2_valid=1` for jalr.
- `cdb_valid` in 1: CDB broadcast valid.
- `cdb_rob_entry` in ROB_W: broadcast tag.
- `cdb_data` in 32: broadcast value.
- `br_ready` in 1: branch unit is idle.
- `rs_br_start` out 1: issue strobe, combinational.
- `issue_op` out OP_W: operation of the issued entry.
- `issue_pc` out 32: PC of the issued entry.
- `issue_bp_prediction` out 1: prediction bit of the issued entry.
- `issue_rob_dest` out ROB_W: ROB entry of the issued entry.
- `issue_q1_data` out 32: operand 1 of the issued entry.
- `issue_q2_data` out 32: operand 2 of the issued entry.
- `count` out $clog2(DEPTH+1): current occupancy.

## Operation

- Each entry stores: `busy`, `op`, `pc`, `bp_prediction`, `rob_dest`, and for each operand `valid`, `tag`, `data`.
- **Occupancy:** entries `[0, count-1]` are busy; entries at and above `count` are don't-care.
- **Dispatch acceptance:**
  - `dispatch_ready = (count < DEPTH)`.
  - A dispatch is accepted when `dispatch_valid & dispatch_ready & ~flush`.
  - A slot freed by a same-cycle issue does not raise `dispatch_ready`.
- **Dispatch capture bypass:** if a dispatched operand is invalid and `cdb_valid & cdb_rob_entry == tag` in the same cycle, the entry is written with that operand valid and holding `cdb_data`.
- **CDB snoop:** every busy entry with an invalid operand whose tag equals `cdb_rob_entry` while `cdb_valid` is high sets that operand valid and latches `cdb_data`.
- **Ready rule:** an entry is ready when both stored operand valid bits are 1. An entry woken by the CDB becomes issuable the cycle after the broadcast; there is no same-cycle CDB-to-issue bypass.
- **Select:**
  - `sel` is the lowest busy ready index.
  - `rs_br_start = br_ready & any_ready & ~flush`.
  - All `issue_*` outputs are driven combinationally from entry `sel`. When `rs_br_start=0`, `issue_*` outputs are don't-care.
- **On an issue edge:**
  - Entries `sel+1 .. count-1` shift down by one.
  - `count` decrements, unless a dispatch is accepted in the same cycle.
  - The CDB snoop applies to entries in their new positions.
- **Dispatch write position:** the new entry is written at index `count` when no issue occurs, or `count-1` when an issue occurs the same cycle. `count` is then unchanged for a simultaneous issue and dispatch.
- **Flush:** on the edge, `count` goes to 0 and all `busy` bits clear. A dispatch and an issue in the flush cycle are both dropped.
- **Reset** (asserted asynchronously, i.e. `rst=0`): `count=0` and all `busy`/`valid` bits are 0. This gives `dispatch_ready=1` and `rs_br_start=0`.

## Timing

- **Dispatch to issue latency** with both operands valid at dispatch: 1 cycle. The entry is written at edge N and can strobe `rs_br_start` in cycle N+1 if `br_ready=1`.
- **CDB wakeup to issue:** broadcast in cycle N, earliest `rs_br_start` in cycle N+1.
- **Handshake:**
  - The branch unit samples `issue_*` on the same edge at which `rs_br_start=1`.
  - The station removes the entry on that edge.
  - `br_ready` is expected to drop for at least one cycle afterwards. If it stays high, back-to-back issue on consecutive cycles is legal.
- **Reset mid-operation:** all entries are lost immediately and asynchronously. After `rst` returns high, the first dispatch is accepted on the next edge.

## Test plan

- **Basic issue:** after reset, dispatch one beq with `q1=5` valid and `q2=5` valid, `rob_dest=3`, `br_ready=1`. Next cycle requires `rs_br_start=1`, `issue_q1_data=5`, `issue_rob_dest=3`, and after that edge `count=0`.
- **CDB wakeup and bypass:**
  - Dispatch bne with `q1` waiting on tag 2 and `q2` valid, while `br_ready=1`. No start is allowed.
  - CDB broadcasts tag 2 with data `0x10` in cycle N. Cycle N+1 requires `rs_br_start=1` and `issue_q1_data=0x10`.
  - Repeat with the CDB match in the dispatch cycle itself: a start is required the next cycle.
- **Fill to full:**
  - Fill 4 entries while holding `br_ready=0`: `dispatch_ready=0` and `count=4`.
  - Raise `br_ready` and dispatch simultaneously. Require issue of entry 0 and that the dispatch is not accepted.
  - Next cycle `dispatch_ready=1`, and the order of the remaining entries is preserved.
- **Oldest-ready select:** entry 0 is waiting and entries 1 and 2 are ready with rob 6 and rob 7. Require issue of rob 6 first, then rob 7, then entry 0 after its CDB wakeup.
- **Simultaneous issue and dispatch** at `count=2`: require `count` to stay 2, with the new entry at index 1 and the previously index-1 entry now at index 0.
- **Flush and reset:**
  - Assert `flush` with 3 entries and a concurrent dispatch. Require `rs_br_start=0` that cycle and `count=0` afterwards.
  - Drop `rst` asynchronously mid-cycle: outputs clear without waiting for a clock edge.
